// File: rtl/scoreboard_pkg.sv
// Shared definitions for the scoreboard game-clock datapath: controller states,
// default timing constants and the display's 7-segment digit patterns.
package scoreboard_pkg;

    localparam int unsigned DEF_PERIOD_MIN  = 12;
    localparam int unsigned DEF_SHOT_SEC    = 24;
    localparam int unsigned DEF_NUM_PERIODS = 4;
    localparam int unsigned DEF_HORN_TICKS  = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_HORN  = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    // Segment order {g,f,e,d,c,b,a}, active high; blank for non-decimal codes.
    function automatic logic [6:0] seg7_digit(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/mmss_countdown.sv
// mm:ss register pair for the period clock. Loads a start value, counts down one
// second per dec, and holds at 0:00.
module mmss_countdown #(
    parameter int unsigned RESET_MIN = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       dec,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       zero,
    output logic       one_left
);

    logic [5:0] r_min;
    logic [5:0] r_sec;
    logic       w_zero;

    assign w_zero = (r_min == 6'd0) && (r_sec == 6'd0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_min <= 6'(RESET_MIN);
            r_sec <= 6'd0;
        end else if (load) begin
            r_min <= load_min;
            r_sec <= load_sec;
        end else if (dec && !w_zero) begin
            if (r_sec == 6'd0) begin
                r_sec <= 6'd59;
                r_min <= r_min - 6'd1;
            end else begin
                r_sec <= r_sec - 6'd1;
            end
        end
    end

    assign minutes  = r_min;
    assign seconds  = r_sec;
    assign zero     = w_zero;
    assign one_left = (r_min == 6'd0) && (r_sec == 6'd1);

endmodule

// File: rtl/game_period_controller.sv
// Game-clock sequencer: run/pause, mm:ss period countdown, shot clock, period
// counter and end-of-period / shot-violation horn.
module game_period_controller
    import scoreboard_pkg::*;
#(
    parameter int unsigned PERIOD_MIN  = DEF_PERIOD_MIN,
    parameter int unsigned SHOT_SEC    = DEF_SHOT_SEC,
    parameter int unsigned NUM_PERIODS = DEF_NUM_PERIODS,
    parameter int unsigned HORN_TICKS  = DEF_HORN_TICKS
) (
    input  logic       clock,
    input  logic       reset,
    // Control inputs are single-cycle, debounced pulses; there is no handshake.
    input  logic       tick,
    input  logic       start_stop,
    input  logic       new_game,
    input  logic       shot_reset,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [4:0] shot_sec,
    output logic       shot_blank,
    output logic [2:0] period,
    output logic       horn,
    output logic       running,
    output logic       game_over,
    output logic [2:0] dbg_state
);

    state_e     r_state;
    state_e     w_next_state;
    logic [4:0] r_shot;
    logic [2:0] r_period;
    logic       r_horn;
    logic [2:0] r_horn_cnt;
    logic       r_shot_viol;
    logic       r_running;
    logic       r_game_over;

    logic       w_zero;
    logic       w_one_left;
    logic       w_tick_run;
    logic       w_game_expire;
    logic       w_shot_expire;
    logic       w_horn_done;
    logic       w_last_period;
    logic       w_next_period;
    logic       w_shot_live;
    logic       w_load;
    logic [11:0] w_remaining;

    assign w_tick_run    = tick && (r_state == ST_RUN);
    assign w_game_expire = w_tick_run && w_one_left;
    // A same-cycle shot_reset reloads the shot clock, so it cannot expire then.
    assign w_shot_expire = w_tick_run && (r_shot == 5'd1) && !shot_reset && !w_game_expire;
    assign w_horn_done   = r_horn && tick && (r_horn_cnt == 3'(HORN_TICKS - 1));
    assign w_last_period = (r_period == 3'(NUM_PERIODS));
    assign w_next_period = w_horn_done && (r_state == ST_HORN) && !w_last_period;
    assign w_shot_live   = (r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign w_load        = new_game || w_next_period;

    mmss_countdown #(
        .RESET_MIN(PERIOD_MIN)
    ) u_mmss (
        .clock    (clock),
        .reset    (reset),
        .load     (w_load),
        .load_min (6'(PERIOD_MIN)),
        .load_sec (6'd0),
        .dec      (w_tick_run && !w_zero),
        .minutes  (minutes),
        .seconds  (seconds),
        .zero     (w_zero),
        .one_left (w_one_left)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start_stop) w_next_state = ST_RUN;
            ST_RUN: begin
                if (w_game_expire)
                    w_next_state = ST_HORN;
                else if (w_shot_expire || start_stop)
                    w_next_state = ST_PAUSE;
            end
            ST_PAUSE: if (start_stop) w_next_state = ST_RUN;
            ST_HORN: begin
                if (w_horn_done)
                    w_next_state = w_last_period ? ST_OVER : ST_IDLE;
            end
            ST_OVER:  w_next_state = ST_OVER;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset || new_game) begin
            r_state     <= ST_IDLE;
            r_shot      <= 5'(SHOT_SEC);
            r_period    <= 3'd1;
            r_horn      <= 1'b0;
            r_horn_cnt  <= 3'd0;
            r_shot_viol <= 1'b0;
            r_running   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_running   <= (w_next_state == ST_RUN);
            r_game_over <= (w_next_state == ST_OVER);

            // Game expiry restarts the horn as an end-of-period horn even if a
            // shot-violation horn was still sounding.
            if (w_game_expire) begin
                r_horn      <= 1'b1;
                r_horn_cnt  <= 3'd0;
                r_shot_viol <= 1'b0;
            end else if (w_shot_expire) begin
                r_horn      <= 1'b1;
                r_horn_cnt  <= 3'd0;
                r_shot_viol <= 1'b1;
            end else if (w_horn_done) begin
                r_horn      <= 1'b0;
                r_horn_cnt  <= 3'd0;
                r_shot_viol <= 1'b0;
            end else if (r_horn && tick) begin
                r_horn_cnt  <= r_horn_cnt + 3'd1;
            end

            if (shot_reset && w_shot_live)
                r_shot <= 5'(SHOT_SEC);
            else if (w_horn_done && r_shot_viol)
                r_shot <= 5'(SHOT_SEC);
            else if (w_next_period)
                r_shot <= 5'(SHOT_SEC);
            else if (w_tick_run && (r_shot != 5'd0))
                r_shot <= r_shot - 5'd1;

            if (w_next_period)
                r_period <= r_period + 3'd1;
        end
    end

    assign w_remaining = (12'(minutes) * 12'd60) + 12'(seconds);
    assign shot_blank  = (w_remaining < 12'(SHOT_SEC));

    assign shot_sec  = r_shot;
    assign period    = r_period;
    assign horn      = r_horn;
    assign running   = r_running;
    assign game_over = r_game_over;
    assign dbg_state = r_state;

endmodule
